// File: rtl/priority_scan_encoder_if.sv
// Request-vector in / per-index beat out handshake bundle for priority_scan_encoder.
// Latency: none, wires only.
// Backpressure: carries in_ready and out_ready; no storage here.
interface priority_scan_encoder_if #(
    parameter int WIDTH = 8
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_none;
    logic             busy;

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_none, busy
    );

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_none, busy
    );
endinterface

// File: rtl/priority_scan_encoder.sv
// Emits the index of every set bit of a captured request vector, one beat each, in priority order.
// Latency: first beat 1 cycle after accept; N set bits take N beats; occupancy max(N,1)+1 cycles.
// Backpressure: beat held stable while out_ready=0; in_ready low until the last beat leaves.
module priority_scan_encoder #(
    parameter int WIDTH     = 8,
    parameter int IDX_W     = $clog2(WIDTH),
    parameter bit MSB_FIRST = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    priority_scan_encoder_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] pend_nxt;
    logic             zero_flag;
    logic             zero_flag_nxt;
    logic [IDX_W-1:0] sel_idx;
    logic             single;
    logic             scanning;
    logic             last_beat;
    logic             in_fire;
    logic             beat_fire;

    // Later matches overwrite earlier ones, so the loop direction sets the priority.
    always_comb begin
        sel_idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (pend[i]) sel_idx = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (pend[i]) sel_idx = IDX_W'(i);
            end
        end
    end

    assign single    = (pend != '0) && ((pend & (pend - WIDTH'(1))) == '0);
    assign scanning  = (state == SCAN);
    assign last_beat = scanning && (zero_flag || single);
    assign in_fire   = bus.in_valid && (state == IDLE);
    assign beat_fire = scanning && bus.out_ready;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = scanning;
    assign bus.busy      = scanning;
    assign bus.out_idx   = (scanning && !zero_flag) ? sel_idx : '0;
    assign bus.out_last  = last_beat;
    assign bus.out_none  = scanning && zero_flag;

    always_comb begin
        state_nxt     = state;
        pend_nxt      = pend;
        zero_flag_nxt = zero_flag;
        case (state)
            IDLE: begin
                if (in_fire) begin
                    pend_nxt      = bus.in_vec;
                    zero_flag_nxt = (bus.in_vec == '0);
                    state_nxt     = SCAN;
                end
            end
            SCAN: begin
                if (beat_fire) begin
                    pend_nxt = pend & ~(WIDTH'(1) << sel_idx);
                    if (last_beat) begin
                        state_nxt     = IDLE;
                        zero_flag_nxt = 1'b0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pend      <= '0;
            zero_flag <= 1'b0;
        end else begin
            state     <= state_nxt;
            pend      <= pend_nxt;
            zero_flag <= zero_flag_nxt;
        end
    end
endmodule
